// File: rtl/alu_flags.sv
// alu_flags: registers the ALU result, applies an optional BCD adjust after
// additions and maintains the 6502 processor status register {N,V,1,B,D,I,Z,C}.
`ifndef ALU_FLAGS_DEFS
`define ALU_FLAGS_DEFS
`define OPP_WIDTH 5
`define REG_WIDTH 8
`define SUM 5'b00001
`define AND 5'b00010
`define OR  5'b00100
`define XOR 5'b01000
`define SR  5'b10000
`endif

module alu_flags #(
  parameter bit DEC_EN = 1'b1
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  wout,
  input  logic [`OPP_WIDTH-1:0] func,
  input  logic [`REG_WIDTH-1:0] add,
  input  logic                  carry_out,
  input  logic                  half_carry,
  input  logic                  overflow,
  input  logic                  dec_mode,
  input  logic                  p_load,
  input  logic [7:0]            p_in,
  input  logic                  flag_wr,
  input  logic [2:0]            flag_sel,
  input  logic                  flag_val,
  output logic [`REG_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  busy,
  output logic [7:0]            status
);

  localparam int unsigned RW    = `REG_WIDTH;
  localparam int unsigned FLG_N = 7;
  localparam int unsigned FLG_V = 6;
  localparam int unsigned FLG_1 = 5;
  localparam int unsigned FLG_B = 4;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_C = 0;
  localparam logic [7:0]  P_RST = 8'h24;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ADJ  = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [RW-1:0] r_result, w_result_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_busy, w_busy_nxt;
  logic [7:0]    r_p, w_p_nxt;
  logic [RW-1:0] r_cap_add, w_cap_add_nxt;
  logic          r_cap_c, w_cap_c_nxt;
  logic          r_cap_h, w_cap_h_nxt;
  logic          r_cap_v, w_cap_v_nxt;

  logic          w_is_dec;
  logic          w_lo_adj;
  logic          w_hi_adj;
  logic [RW-1:0] w_t1;
  logic [RW-1:0] w_t2;

  // Decimal adjust of the captured sum: low nibble first, then high nibble.
  assign w_lo_adj = r_cap_h | (r_cap_add[3:0] > 4'd9);
  assign w_t1     = r_cap_add + (w_lo_adj ? RW'(8'h06) : RW'(8'h00));
  assign w_hi_adj = r_cap_c | (w_t1 > RW'(8'h99));
  assign w_t2     = w_t1 + (w_hi_adj ? RW'(8'h60) : RW'(8'h00));

  assign w_is_dec = DEC_EN && (func == `SUM) && dec_mode;

  // State, result, capture and status registers.
  always_ff @(posedge phi1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_p       <= P_RST;
      r_cap_add <= '0;
      r_cap_c   <= 1'b0;
      r_cap_h   <= 1'b0;
      r_cap_v   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_result  <= w_result_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_p       <= w_p_nxt;
      r_cap_add <= w_cap_add_nxt;
      r_cap_c   <= w_cap_c_nxt;
      r_cap_h   <= w_cap_h_nxt;
      r_cap_v   <= w_cap_v_nxt;
    end
  end

  // Next state, result and flags; explicit loads override ALU flag updates.
  always_comb begin
    w_state_nxt   = r_state;
    w_result_nxt  = r_result;
    w_valid_nxt   = 1'b0;
    w_busy_nxt    = 1'b0;
    w_p_nxt       = r_p;
    w_cap_add_nxt = r_cap_add;
    w_cap_c_nxt   = r_cap_c;
    w_cap_h_nxt   = r_cap_h;
    w_cap_v_nxt   = r_cap_v;

    case (r_state)
      S_IDLE: begin
        if (wout) begin
          if (w_is_dec) begin
            w_cap_add_nxt = add;
            w_cap_c_nxt   = carry_out;
            w_cap_h_nxt   = half_carry;
            w_cap_v_nxt   = overflow;
            w_busy_nxt    = 1'b1;
            w_state_nxt   = S_ADJ;
          end else begin
            w_result_nxt = add;
            w_valid_nxt  = 1'b1;
            case (func)
              `SUM: begin
                w_p_nxt[FLG_N] = add[RW-1];
                w_p_nxt[FLG_Z] = (add == '0);
                w_p_nxt[FLG_C] = carry_out;
                w_p_nxt[FLG_V] = overflow;
              end
              `AND, `OR, `XOR: begin
                w_p_nxt[FLG_N] = add[RW-1];
                w_p_nxt[FLG_Z] = (add == '0);
              end
              `SR: begin
                w_p_nxt[FLG_N] = add[RW-1];
                w_p_nxt[FLG_Z] = (add == '0);
                w_p_nxt[FLG_C] = carry_out;
              end
              default: ;
            endcase
          end
        end
      end
      S_ADJ: begin
        w_result_nxt   = w_t2;
        w_valid_nxt    = 1'b1;
        w_p_nxt[FLG_N] = w_t2[RW-1];
        w_p_nxt[FLG_Z] = (w_t2 == '0);
        w_p_nxt[FLG_C] = r_cap_c | w_hi_adj;
        w_p_nxt[FLG_V] = r_cap_v;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (flag_wr && (flag_sel != 3'(FLG_B)) && (flag_sel != 3'(FLG_1))) begin
      w_p_nxt[flag_sel] = flag_val;
    end
    if (p_load) begin
      w_p_nxt = p_in;
    end
    w_p_nxt[FLG_1] = 1'b1;
    w_p_nxt[FLG_B] = 1'b0;
  end

  assign result       = r_result;
  assign result_valid = r_valid;
  assign busy         = r_busy;
  assign status       = r_p;

endmodule

// File: tb/tb_alu_flags.sv
// tb_alu_flags: directed and randomized checks of alu_flags with decimal
// adjust enabled (index 0) and disabled (index 1).
module tb_alu_flags;

  localparam logic [4:0] F_SUM = 5'b00001;
  localparam logic [4:0] F_AND = 5'b00010;
  localparam logic [4:0] F_OR  = 5'b00100;
  localparam logic [4:0] F_XOR = 5'b01000;
  localparam logic [4:0] F_SR  = 5'b10000;

  logic       phi1;
  logic       reset_n;
  logic       wout;
  logic [4:0] func;
  logic [7:0] add;
  logic       carry_out, half_carry, overflow, dec_mode;
  logic       p_load;
  logic [7:0] p_in;
  logic       flag_wr;
  logic [2:0] flag_sel;
  logic       flag_val;

  logic [7:0] res_d, res_b, st_d, st_b;
  logic       vld_d, vld_b, bsy_d, bsy_b;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state, per instance.
  logic [7:0] m_st[2];
  logic [7:0] m_res[2];
  logic       m_vld[2];
  logic       m_bsy[2];
  logic [7:0] m_cap_add[2];
  logic       m_cap_c[2], m_cap_h[2], m_cap_v[2];

  alu_flags #(.DEC_EN(1'b1)) u_dut_d (
    .phi1(phi1), .reset_n(reset_n), .wout(wout), .func(func), .add(add),
    .carry_out(carry_out), .half_carry(half_carry), .overflow(overflow),
    .dec_mode(dec_mode), .p_load(p_load), .p_in(p_in), .flag_wr(flag_wr),
    .flag_sel(flag_sel), .flag_val(flag_val), .result(res_d),
    .result_valid(vld_d), .busy(bsy_d), .status(st_d)
  );

  alu_flags #(.DEC_EN(1'b0)) u_dut_b (
    .phi1(phi1), .reset_n(reset_n), .wout(wout), .func(func), .add(add),
    .carry_out(carry_out), .half_carry(half_carry), .overflow(overflow),
    .dec_mode(dec_mode), .p_load(p_load), .p_in(p_in), .flag_wr(flag_wr),
    .flag_sel(flag_sel), .flag_val(flag_val), .result(res_b),
    .result_valid(vld_b), .busy(bsy_b), .status(st_b)
  );

  initial phi1 = 1'b0;
  always #5 phi1 = ~phi1;

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  task automatic idle_inputs();
    wout = 1'b0; func = 5'd0; add = 8'h00;
    carry_out = 1'b0; half_carry = 1'b0; overflow = 1'b0; dec_mode = 1'b0;
    p_load = 1'b0; p_in = 8'h00; flag_wr = 1'b0; flag_sel = 3'd0; flag_val = 1'b0;
  endtask

  // Next-state reference: BCD correction written with integer arithmetic.
  task automatic model_edge(input int k);
    int t;
    bit hi;
    logic [7:0] st, res;
    logic vld, bsy;
    st = m_st[k]; res = m_res[k]; vld = 1'b0; bsy = 1'b0;
    if (m_bsy[k]) begin
      t = int'(m_cap_add[k]);
      if (m_cap_h[k] || (t % 16) > 9) t = (t + 6) % 256;
      hi = m_cap_c[k] || (t > 153);
      if (hi) t = (t + 96) % 256;
      res = 8'(t); vld = 1'b1;
      st[7] = res[7]; st[1] = (res == 8'h00); st[0] = m_cap_c[k] || hi; st[6] = m_cap_v[k];
    end else if (wout) begin
      if (k == 0 && func == F_SUM && dec_mode) begin
        m_cap_add[k] = add; m_cap_c[k] = carry_out; m_cap_h[k] = half_carry;
        m_cap_v[k] = overflow; bsy = 1'b1;
      end else begin
        res = add; vld = 1'b1;
        if (func == F_SUM || func == F_AND || func == F_OR || func == F_XOR || func == F_SR) begin
          st[7] = add[7]; st[1] = (add == 8'h00);
        end
        if (func == F_SUM || func == F_SR) st[0] = carry_out;
        if (func == F_SUM) st[6] = overflow;
      end
    end
    if (flag_wr && flag_sel != 3'd4 && flag_sel != 3'd5) st[flag_sel] = flag_val;
    if (p_load) st = (p_in & 8'hCF) | 8'h20;
    m_st[k] = st; m_res[k] = res; m_vld[k] = vld; m_bsy[k] = bsy;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 8'h24; m_res[k] = 8'h00; m_vld[k] = 1'b0; m_bsy[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b1;
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (st_d !== 8'h24) begin n_fail++; $display("FAIL reset_status_d: got %h want 24", st_d); end
    n_chk++; if (st_b !== 8'h24) begin n_fail++; $display("FAIL reset_status_b: got %h want 24", st_b); end
    n_chk++; if (res_d !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", res_d); end
    n_chk++; if (bsy_d !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bsy_d); end
    n_chk++; if (vld_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", vld_d); end
    @(negedge phi1) reset_n = 1'b1;
    tick();
    n_chk++; if (vld_d !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle_valid: got %b want 0", vld_d); end
  endtask

  task automatic test_binary_sum();
    idle_inputs();
    wout = 1'b1; func = F_SUM; add = 8'h00; carry_out = 1'b1;
    tick();
    idle_inputs();
    n_chk++; if (res_d !== 8'h00) begin n_fail++; $display("FAIL bin_sum_result: got %h want 00", res_d); end
    n_chk++; if (vld_d !== 1'b1) begin n_fail++; $display("FAIL bin_sum_valid_d: got %b want 1", vld_d); end
    n_chk++; if (vld_b !== 1'b1) begin n_fail++; $display("FAIL bin_sum_valid_b: got %b want 1", vld_b); end
    n_chk++; if (st_d !== 8'h27) begin n_fail++; $display("FAIL bin_sum_status_d: got %h want 27", st_d); end
    n_chk++; if (st_b !== 8'h27) begin n_fail++; $display("FAIL bin_sum_status_b: got %h want 27", st_b); end
    n_chk++; if (bsy_d !== 1'b0) begin n_fail++; $display("FAIL bin_sum_busy: got %b want 0", bsy_d); end
    tick();
    n_chk++; if (vld_d !== 1'b0) begin n_fail++; $display("FAIL bin_sum_pulse_end: got %b want 0", vld_d); end
    n_chk++; if (res_d !== 8'h00) begin n_fail++; $display("FAIL bin_sum_hold: got %h want 00", res_d); end
  endtask

  task automatic test_decimal_sum();
    idle_inputs();
    wout = 1'b1; func = F_SUM; add = 8'h32; carry_out = 1'b1; half_carry = 1'b1; dec_mode = 1'b1;
    tick();
    n_chk++; if (bsy_d !== 1'b1) begin n_fail++; $display("FAIL dec_busy: got %b want 1", bsy_d); end
    n_chk++; if (vld_d !== 1'b0) begin n_fail++; $display("FAIL dec_early_valid: got %b want 0", vld_d); end
    n_chk++; if (vld_b !== 1'b1 || res_b !== 8'h32) begin n_fail++; $display("FAIL dec_off_lat1: got %b/%h want 1/32", vld_b, res_b); end
    idle_inputs();
    wout = 1'b1; func = F_AND; add = 8'h55;
    tick();
    idle_inputs();
    n_chk++; if (res_d !== 8'h98) begin n_fail++; $display("FAIL dec_result: got %h want 98", res_d); end
    n_chk++; if (vld_d !== 1'b1) begin n_fail++; $display("FAIL dec_valid: got %b want 1", vld_d); end
    n_chk++; if (bsy_d !== 1'b0) begin n_fail++; $display("FAIL dec_busy_end: got %b want 0", bsy_d); end
    n_chk++; if (st_d !== 8'hA5) begin n_fail++; $display("FAIL dec_status: got %h want a5", st_d); end
    tick();
    n_chk++; if (vld_d !== 1'b0 || res_d !== 8'h98) begin n_fail++; $display("FAIL dec_busy_wout_ignored: got %b/%h want 0/98", vld_d, res_d); end
  endtask

  task automatic test_decimal_no_carry();
    idle_inputs();
    wout = 1'b1; func = F_SUM; add = 8'h1A; dec_mode = 1'b1;
    tick();
    idle_inputs();
    n_chk++; if (res_b !== 8'h1A || vld_b !== 1'b1) begin n_fail++; $display("FAIL dec_nc_off: got %h/%b want 1a/1", res_b, vld_b); end
    n_chk++; if (bsy_d !== 1'b1) begin n_fail++; $display("FAIL dec_nc_busy: got %b want 1", bsy_d); end
    tick();
    n_chk++; if (res_d !== 8'h20 || vld_d !== 1'b1) begin n_fail++; $display("FAIL dec_nc_result: got %h/%b want 20/1", res_d, vld_d); end
    n_chk++; if (st_d[0] !== 1'b0 || st_d[7] !== 1'b0 || st_d[1] !== 1'b0) begin n_fail++; $display("FAIL dec_nc_flags: got %h want C=0 N=0 Z=0", st_d); end
    tick();
  endtask

  task automatic test_priority();
    idle_inputs();
    p_load = 1'b1; p_in = 8'hC3; flag_wr = 1'b1; flag_sel = 3'd0; flag_val = 1'b0;
    wout = 1'b1; func = F_SUM; add = 8'h00; carry_out = 1'b1;
    tick();
    idle_inputs();
    n_chk++; if (st_d !== 8'hE3) begin n_fail++; $display("FAIL prio_status_d: got %h want e3", st_d); end
    n_chk++; if (st_b !== 8'hE3) begin n_fail++; $display("FAIL prio_status_b: got %h want e3", st_b); end
    n_chk++; if (vld_d !== 1'b1) begin n_fail++; $display("FAIL prio_valid: got %b want 1", vld_d); end
    tick();
  endtask

  task automatic test_reset_mid_adj();
    idle_inputs();
    wout = 1'b1; func = F_SUM; add = 8'h32; carry_out = 1'b1; half_carry = 1'b1; dec_mode = 1'b1;
    tick();
    idle_inputs();
    n_chk++; if (bsy_d !== 1'b1) begin n_fail++; $display("FAIL rst_adj_busy_pre: got %b want 1", bsy_d); end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (st_d !== 8'h24 || bsy_d !== 1'b0) begin n_fail++; $display("FAIL rst_adj_async: got %h/%b want 24/0", st_d, bsy_d); end
    #2 reset_n = 1'b1;
    tick();
    n_chk++; if (vld_d !== 1'b0 || res_d !== 8'h00) begin n_fail++; $display("FAIL rst_adj_no_pulse: got %b/%h want 0/00", vld_d, res_d); end
    test_binary_sum();
  endtask

  task automatic test_random();
    int r;
    logic [7:0] o_res[2], o_st[2];
    logic o_vld[2], o_bsy[2];
    idle_inputs();
    tick();
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 400; i++) begin
      wout = ($urandom_range(0, 9) < 7);
      r = $urandom_range(0, 7);
      if (r < 5) func = 5'(1 << r);
      else if (r == 5) func = 5'd0;
      else if (r == 6) func = 5'($urandom);
      else func = F_SUM;
      add = 8'($urandom);
      carry_out = 1'($urandom); half_carry = 1'($urandom);
      overflow = 1'($urandom); dec_mode = 1'($urandom);
      p_load = ($urandom_range(0, 9) == 0);
      p_in = 8'($urandom);
      flag_wr = ($urandom_range(0, 4) == 0);
      flag_sel = 3'($urandom); flag_val = 1'($urandom);
      model_edge(0);
      model_edge(1);
      tick();
      o_res[0] = res_d; o_res[1] = res_b; o_st[0] = st_d; o_st[1] = st_b;
      o_vld[0] = vld_d; o_vld[1] = vld_b; o_bsy[0] = bsy_d; o_bsy[1] = bsy_b;
      for (int k = 0; k < 2; k++) begin
        n_chk++; if (o_res[k] !== m_res[k]) begin n_fail++; $display("FAIL rnd_result[%0d] cyc %0d: got %h want %h", k, i, o_res[k], m_res[k]); end
        n_chk++; if (o_vld[k] !== m_vld[k]) begin n_fail++; $display("FAIL rnd_valid[%0d] cyc %0d: got %b want %b", k, i, o_vld[k], m_vld[k]); end
        n_chk++; if (o_bsy[k] !== m_bsy[k]) begin n_fail++; $display("FAIL rnd_busy[%0d] cyc %0d: got %b want %b", k, i, o_bsy[k], m_bsy[k]); end
        n_chk++; if (o_st[k] !== m_st[k]) begin n_fail++; $display("FAIL rnd_status[%0d] cyc %0d: got %h want %h", k, i, o_st[k], m_st[k]); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_binary_sum();
    test_decimal_sum();
    test_decimal_no_carry();
    test_priority();
    test_reset_mid_adj();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
